// File: rtl/io_outputs_pkg.sv
// Shared types and defaults for the 9-pad LVCMOS33 output driver bank.
package io_outputs_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_DISARM = 2'd3
  } state_e;

  localparam int         DEF_WIDTH      = 9;
  localparam logic [8:0] DEF_SAFE_VALUE = 9'h000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/io_readback_chk.sv
// Readback supervision: synchronises pad readback, waits for the pads to settle after
// any drive change, then latches sticky per-bit mismatches.
module io_readback_chk import io_outputs_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 3,
  parameter int CW     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_out,
  input  logic             pad_oe,
  input  logic [WIDTH-1:0] pad_out_nxt,
  input  logic             pad_oe_nxt,
  input  logic [WIDTH-1:0] readback,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] fault
);

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);

  logic [WIDTH-1:0] rb_meta_r;
  logic [WIDTH-1:0] rb_sync_r;
  logic [CW-1:0]    settle_r;
  logic [WIDTH-1:0] fault_r;
  logic             change_s;
  logic [WIDTH-1:0] mism_s;

  // The reload happens on the edge that changes the drive, so the count covers the synchroniser delay.
  always_comb begin
    change_s = 1'b0;
    mism_s   = '0;
    change_s = (pad_out_nxt != pad_out) || (pad_oe_nxt != pad_oe);
    if ((settle_r == '0) && pad_oe) begin
      mism_s = rb_sync_r ^ pad_out;
    end else begin
      mism_s = '0;
    end
  end

  // Synchroniser, settle counter and sticky fault register; a fresh mismatch beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_meta_r <= '0;
      rb_sync_r <= '0;
      settle_r  <= SETTLE_LOAD;
      fault_r   <= '0;
    end else begin
      rb_meta_r <= readback;
      rb_sync_r <= rb_meta_r;
      if (change_s) begin
        settle_r <= SETTLE_LOAD;
      end else if (settle_r != '0) begin
        settle_r <= settle_r - CW'(1);
      end else begin
        settle_r <= settle_r;
      end
      fault_r <= (fault_clr ? '0 : fault_r) | mism_s;
    end
  end

  assign fault = fault_r;

endmodule

// File: rtl/io_outputs_drv.sv
// Output pad driver: arm/disarm OE sequencing, registered write path with one-shot
// pulse bits, write handshake, and readback fault supervision.
module io_outputs_drv import io_outputs_pkg::*; #(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SAFE_VALUE  = WIDTH'(DEF_SAFE_VALUE),
  parameter int               OE_DELAY    = 4,
  parameter int               PULSE_WIDTH = 8,
  parameter int               SETTLE      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_req,
  output logic             wr_ack,
  output logic             wr_rej,
  input  logic [WIDTH-1:0] pulse_mask,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  input  logic [WIDTH-1:0] readback,
  output logic [WIDTH-1:0] fault,
  input  logic             fault_clr,
  output logic             busy
);

  localparam int            CW      = $clog2(max3(OE_DELAY, PULSE_WIDTH, SETTLE) + 1);
  localparam logic [CW-1:0] OE_LOAD = CW'(OE_DELAY - 1);
  localparam logic [CW-1:0] PW_LOAD = CW'(PULSE_WIDTH - 1);

  state_e           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [CW-1:0]    pcnt_r, pcnt_nxt_s;
  logic             pulse_act_r, pulse_act_nxt_s;
  logic [WIDTH-1:0] pmask_r, pmask_nxt_s;
  logic [WIDTH-1:0] pad_out_r, pad_out_nxt_s;
  logic [WIDTH-1:0] pad_oe_r, pad_oe_nxt_s;
  logic             ack_r, ack_nxt_s;
  logic             rej_r, rej_nxt_s;
  logic             busy_r, busy_nxt_s;

  // Next-state, datapath and handshake decode; every output is registered from these values.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    pcnt_nxt_s      = pcnt_r;
    pulse_act_nxt_s = pulse_act_r;
    pmask_nxt_s     = pmask_r;
    pad_out_nxt_s   = pad_out_r;
    ack_nxt_s       = 1'b0;
    rej_nxt_s       = 1'b0;
    case (state_r)
      ST_OFF: begin
        pad_out_nxt_s   = SAFE_VALUE;
        pulse_act_nxt_s = 1'b0;
        rej_nxt_s       = wr_req;
        if (enable) begin
          state_nxt_s = ST_ARM;
          cnt_nxt_s   = OE_LOAD;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      ST_ARM: begin
        pad_out_nxt_s = SAFE_VALUE;
        rej_nxt_s     = wr_req;
        if (!enable) begin
          state_nxt_s = ST_OFF;
        end else if (cnt_r == '0) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          // Disarm aborts any pulse; a request seen here is refused once in DISARM.
          state_nxt_s     = ST_DISARM;
          cnt_nxt_s       = OE_LOAD;
          pad_out_nxt_s   = SAFE_VALUE;
          pulse_act_nxt_s = 1'b0;
          pmask_nxt_s     = '0;
        end else if (pulse_act_r) begin
          if (pcnt_r == '0) begin
            pulse_act_nxt_s = 1'b0;
            pad_out_nxt_s   = (pad_out_r & ~pmask_r) | (SAFE_VALUE & pmask_r);
          end else begin
            pcnt_nxt_s = pcnt_r - CW'(1);
          end
        end else if (wr_req && !busy_r) begin
          pad_out_nxt_s = wr_data;
          ack_nxt_s     = 1'b1;
          if (pulse_mask != '0) begin
            pulse_act_nxt_s = 1'b1;
            pmask_nxt_s     = pulse_mask;
            pcnt_nxt_s      = PW_LOAD;
          end else begin
            pmask_nxt_s = '0;
          end
        end else begin
          pad_out_nxt_s = pad_out_r;
        end
      end
      ST_DISARM: begin
        pad_out_nxt_s = SAFE_VALUE;
        rej_nxt_s     = wr_req;
        if (cnt_r == '0) begin
          state_nxt_s = ST_OFF;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s     = ST_OFF;
        pad_out_nxt_s   = SAFE_VALUE;
        pulse_act_nxt_s = 1'b0;
      end
    endcase
    pad_oe_nxt_s = ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_DISARM)) ? '1 : '0;
    busy_nxt_s   = (state_nxt_s != ST_RUN) || pulse_act_nxt_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_OFF;
      cnt_r       <= '0;
      pcnt_r      <= '0;
      pulse_act_r <= 1'b0;
      pmask_r     <= '0;
      pad_out_r   <= SAFE_VALUE;
      pad_oe_r    <= '0;
      ack_r       <= 1'b0;
      rej_r       <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pcnt_r      <= pcnt_nxt_s;
      pulse_act_r <= pulse_act_nxt_s;
      pmask_r     <= pmask_nxt_s;
      pad_out_r   <= pad_out_nxt_s;
      pad_oe_r    <= pad_oe_nxt_s;
      ack_r       <= ack_nxt_s;
      rej_r       <= rej_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  io_readback_chk #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE),
    .CW     (CW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_out     (pad_out_r),
    .pad_oe      (pad_oe_r[0]),
    .pad_out_nxt (pad_out_nxt_s),
    .pad_oe_nxt  (pad_oe_nxt_s[0]),
    .readback    (readback),
    .fault_clr   (fault_clr),
    .fault       (fault)
  );

  assign pad_out = pad_out_r;
  assign pad_oe  = pad_oe_r;
  assign wr_ack  = ack_r;
  assign wr_rej  = rej_r;
  assign busy    = busy_r;

endmodule
